// File: rtl/background_line_prefetch.sv
`timescale 1ns/1ps
// background_line_prefetch
//
// Purpose:
//   Streams one 320-entry source row from the single-port background RAM into
//   a back line buffer during each scan line. At the next line start the
//   buffers swap, and the front buffer serves 2x-upscaled pixels for the line
//   being drawn. A horizontal scroll offset, sampled at line start, is baked
//   into the buffer order, and the source column wraps around at the row end.
//
// Ports:
//   Clk             in   1  system clock (DrawX/DrawY each hold for 2 cycles)
//   Reset           in   1  synchronous active-high reset
//   DrawX           in  10  current horizontal pixel, 0..799
//   DrawY           in  10  current line, 0..524
//   scroll_x        in   9  horizontal source offset in entries
//   read_address    out 19  background RAM address (valid while fetching)
//   background_data in   4  RAM read data, valid 1 cycle after read_address
//   pixel_data      out  4  registered palette index for (DrawX, DrawY)
//   busy            out  1  a row fetch is in progress
//   overrun         out  1  sticky: a line start arrived during a fetch
module background_line_prefetch #(
    parameter int RESHAPE_LENGTH = 320,
    parameter int SCREEN_LENGTH  = 640,
    parameter int SCREEN_WIDTH   = 480,
    parameter int V_TOTAL        = 525
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [8:0]  scroll_x,
    output logic [18:0] read_address,
    input  logic [3:0]  background_data,
    output logic [3:0]  pixel_data,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [9:0]  r_prev_drawx;
    logic [8:0]  r_i;            // column counter of the running fetch
    logic [8:0]  r_s;            // reduced scroll offset for this fetch
    logic [18:0] r_row_base;
    logic [8:0]  r_i_d;          // buffer index of the datum arriving now
    logic        r_valid_d;
    logic        r_front_sel;    // which physical buffer is the front
    logic        r_front_valid;
    logic        r_back_complete;
    logic        r_overrun;
    logic [3:0]  r_pixel;

    logic        w_line_start;
    logic [9:0]  w_next_y;
    logic        w_fetch_req;
    logic [8:0]  w_src_row;
    logic [18:0] w_row_base;
    logic [8:0]  w_scroll;
    logic [9:0]  w_col_sum;
    logic [9:0]  w_col;
    logic        w_busy;
    logic        w_last_col;
    logic        w_swap;
    logic        w_front_sel_now;
    logic        w_front_valid_now;
    logic        w_in_view;
    logic [8:0]  w_rd_idx;
    logic [3:0]  w_rd_data [2];

    // ------------------------------------------------------------------
    // Line bookkeeping
    // ------------------------------------------------------------------
    assign w_line_start = (DrawX == 10'd0) && (r_prev_drawx != 10'd0);
    assign w_next_y     = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
    assign w_fetch_req  = (w_next_y < 10'(SCREEN_WIDTH));
    assign w_src_row    = w_next_y[9:1];
    assign w_row_base   = 19'(w_src_row) * 19'(RESHAPE_LENGTH);
    assign w_scroll     = (scroll_x >= 9'(RESHAPE_LENGTH)) ?
                          scroll_x - 9'(RESHAPE_LENGTH) : scroll_x;

    // Both operands are below 320, so one conditional subtract wraps the column.
    assign w_col_sum  = {1'b0, r_i} + {1'b0, r_s};
    assign w_col      = (w_col_sum >= 10'(RESHAPE_LENGTH)) ?
                        w_col_sum - 10'(RESHAPE_LENGTH) : w_col_sum;

    assign w_busy     = (r_state != ST_IDLE);
    assign w_last_col = (r_i == 9'(RESHAPE_LENGTH - 1));

    // A completed back buffer is promoted only when no fetch is in flight;
    // a line start during a fetch aborts it instead.
    assign w_swap            = w_line_start && !w_busy && r_back_complete;
    // The pixel read in the line-start cycle already sees the swapped buffer,
    // so the first pixel of a line comes from that line's data.
    assign w_front_sel_now   = r_front_sel ^ w_swap;
    assign w_front_valid_now = r_front_valid | w_swap;

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        read_address = '0;
        busy         = w_busy;
        if (w_line_start) begin
            // Line start wins over every state: it starts a fresh fetch
            // from column 0 or parks the FSM when no row is needed.
            w_state_next = w_fetch_req ? ST_ISSUE : ST_IDLE;
        end else begin
            case (r_state)
                ST_ISSUE: if (w_last_col) w_state_next = ST_DRAIN;
                ST_DRAIN: w_state_next = ST_IDLE;
                default:  w_state_next = r_state;
            endcase
        end
        if (r_state == ST_ISSUE) begin
            read_address = r_row_base + 19'(w_col);
        end
    end

    // ------------------------------------------------------------------
    // Counters, capture pipeline, buffer control and pixel output
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_prev_drawx    <= 10'h3FF;
            r_i             <= '0;
            r_s             <= '0;
            r_row_base      <= '0;
            r_i_d           <= '0;
            r_valid_d       <= 1'b0;
            r_front_sel     <= 1'b0;
            r_front_valid   <= 1'b0;
            r_back_complete <= 1'b0;
            r_overrun       <= 1'b0;
            r_pixel         <= '0;
        end else begin
            r_prev_drawx <= DrawX;
            r_valid_d    <= (r_state == ST_ISSUE);
            r_i_d        <= r_i;

            if (w_line_start) begin
                r_i        <= '0;
                r_s        <= w_scroll;
                r_row_base <= w_row_base;
                if (w_busy) begin
                    r_overrun       <= 1'b1;
                    r_back_complete <= 1'b0;
                end else if (r_back_complete) begin
                    r_front_sel     <= ~r_front_sel;
                    r_front_valid   <= 1'b1;
                    r_back_complete <= 1'b0;
                end
            end else begin
                if (r_state == ST_ISSUE) begin
                    r_i <= r_i + 9'd1;
                end
                // The last datum is written in this same cycle.
                if (r_state == ST_DRAIN) begin
                    r_back_complete <= 1'b1;
                end
            end

            r_pixel <= (w_in_view && w_front_valid_now) ?
                       w_rd_data[w_front_sel_now] : 4'd0;
        end
    end

    assign w_in_view = (DrawX < 10'(SCREEN_LENGTH)) && (DrawY < 10'(SCREEN_WIDTH));
    assign w_rd_idx  = DrawX[9:1];

    // ------------------------------------------------------------------
    // Two line buffers; the one not selected as front takes the writes.
    // Index is the fetch order, so the scroll is already applied.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line_buf
            logic [3:0] r_mem [RESHAPE_LENGTH];

            always_ff @(posedge Clk) begin
                if (r_valid_d && (r_front_sel != 1'(gi))) begin
                    r_mem[r_i_d] <= background_data;
                end
            end

            assign w_rd_data[gi] = r_mem[w_rd_idx];
        end
    endgenerate

    assign pixel_data = r_pixel;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_background_line_prefetch.sv
`timescale 1ns/1ps
module tb_background_line_prefetch;

    logic        Clk;
    logic        Reset;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [8:0]  scroll_x;
    logic [18:0] read_address;
    logic [3:0]  background_data;
    logic [3:0]  pixel_data;
    logic        busy;
    logic        overrun;

    int compared = 0;
    int failed   = 0;
    int busy_cnt = 0;
    bit ram_mode = 1'b0;

    logic [18:0] obs_addr_q [$];
    logic [18:0] exp_addr_q [$];
    logic [3:0]  obs_pix_q  [$];
    logic [3:0]  exp_pix_q  [$];

    // Line-level reference model: one front row, one pending row.
    logic [3:0] m_front   [320];
    logic [3:0] m_pending [320];
    bit m_front_valid, m_pending_valid, m_fetching, m_overrun;

    background_line_prefetch dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .DrawX           (DrawX),
        .DrawY           (DrawY),
        .scroll_x        (scroll_x),
        .read_address    (read_address),
        .background_data (background_data),
        .pixel_data      (pixel_data),
        .busy            (busy),
        .overrun         (overrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [3:0] ram_f(input logic [18:0] a);
        if (ram_mode) return a[3:0] ^ a[7:4] ^ a[11:8];
        return a[3:0];
    endfunction

    // Synchronous-read RAM: data valid one cycle after the address.
    initial background_data = 4'd0;
    always @(posedge Clk) background_data <= ram_f(read_address);

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    task automatic m_reset();
        m_front_valid = 0; m_pending_valid = 0; m_fetching = 0; m_overrun = 0;
    endtask

    task automatic m_line_start(input int y, input int scr);
        int ny, row, s, addr;
        if (m_fetching) begin
            m_overrun = 1; m_fetching = 0; m_pending_valid = 0;
        end else if (m_pending_valid) begin
            m_front = m_pending; m_front_valid = 1; m_pending_valid = 0;
        end
        ny = (y == 524) ? 0 : y + 1;
        s  = scr % 320;
        exp_addr_q.delete();
        if (ny < 480) begin
            row = ny / 2;
            for (int k = 0; k < 320; k++) begin
                addr = row * 320 + (k + s) % 320;
                exp_addr_q.push_back(19'(addr));
                m_pending[k] = ram_f(19'(addr));
            end
            m_fetching = 1;
        end
    endtask

    task automatic m_complete();
        if (m_fetching) begin m_fetching = 0; m_pending_valid = 1; end
    endtask

    // ---------------- drivers ----------------
    task automatic clear_obs();
        obs_addr_q.delete(); obs_pix_q.delete(); exp_pix_q.delete(); busy_cnt = 0;
    endtask

    task automatic tick();
        int x, y;
        logic [3:0] e;
        x = int'(DrawX); y = int'(DrawY);
        e = 4'd0;
        if (x < 640 && y < 480 && m_front_valid) e = m_front[x >> 1];
        @(posedge Clk); #1;
        if (busy) begin busy_cnt++; obs_addr_q.push_back(read_address); end
        obs_pix_q.push_back(pixel_data);
        exp_pix_q.push_back(e);
    endtask

    task automatic drive_line(input int y, input int scr);
        DrawY = 10'(y); scroll_x = 9'(scr); DrawX = 10'd0;
        m_line_start(y, scr);
        for (int x = 0; x < 800; x++) begin
            DrawX = 10'(x);
            tick(); tick();
        end
        m_complete();
    endtask

    task automatic partial_line(input int y, input int scr, input int nticks);
        DrawY = 10'(y); scroll_x = 9'(scr); DrawX = 10'd0;
        m_line_start(y, scr);
        for (int t = 0; t < nticks; t++) begin
            DrawX = 10'(t / 2);
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset = 1'b1; DrawX = 10'd799; DrawY = 10'd0; scroll_x = 9'd0;
        m_reset();
        repeat (3) @(posedge Clk);
        #1;
        compared++; if (read_address !== 19'd0) begin failed++; $display("FAIL reset_addr: got %0d need 0", read_address); end
        compared++; if (pixel_data !== 4'd0) begin failed++; $display("FAIL reset_pix: got %0d need 0", pixel_data); end
        compared++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %0b need 0", busy); end
        compared++; if (overrun !== 1'b0) begin failed++; $display("FAIL reset_overrun: got %0b need 0", overrun); end
        Reset = 1'b0;
        clear_obs();
        repeat (10) tick();
        compared++; if (busy_cnt !== 0) begin failed++; $display("FAIL idle_no_fetch: busy cycles got %0d need 0", busy_cnt); end
        compared++; if (read_address !== 19'd0) begin failed++; $display("FAIL idle_addr: got %0d need 0", read_address); end
    endtask

    task automatic test_fetch_scroll0();
        int nbad, fk;
        clear_obs();
        drive_line(1, 0);
        compared++; if (busy_cnt !== 321) begin failed++; $display("FAIL fetch0_busy_len: got %0d need 321", busy_cnt); end
        compared++; if (obs_addr_q.size() < 320 || obs_addr_q[0] !== 19'd320) begin failed++; $display("FAIL fetch0_first: got %0d need 320", (obs_addr_q.size() > 0) ? obs_addr_q[0] : 19'd0); end
        compared++; if (obs_addr_q.size() < 320 || obs_addr_q[319] !== 19'd639) begin failed++; $display("FAIL fetch0_last: got %0d need 639", (obs_addr_q.size() >= 320) ? obs_addr_q[319] : 19'd0); end
        nbad = 0; fk = 0;
        for (int k = 0; k < exp_addr_q.size(); k++)
            if (k >= obs_addr_q.size() || obs_addr_q[k] !== exp_addr_q[k]) begin if (nbad == 0) fk = k; nbad++; end
        compared++; if (nbad != 0) begin failed++; $display("FAIL fetch0_seq: %0d wrong, first col %0d got %0d need %0d", nbad, fk, (fk < obs_addr_q.size()) ? obs_addr_q[fk] : 19'd0, exp_addr_q[fk]); end
    endtask

    task automatic test_scroll();
        int nbad, fk;
        clear_obs();
        drive_line(1, 300);
        compared++; if (busy_cnt !== 321) begin failed++; $display("FAIL scroll_busy_len: got %0d need 321", busy_cnt); end
        if (obs_addr_q.size() < 320) begin
            compared++; failed++;
            $display("FAIL scroll_count: got %0d addresses need 320", obs_addr_q.size());
        end else begin
            compared++; if (obs_addr_q[0] !== 19'd620) begin failed++; $display("FAIL scroll_1st: got %0d need 620", obs_addr_q[0]); end
            compared++; if (obs_addr_q[19] !== 19'd639) begin failed++; $display("FAIL scroll_20th: got %0d need 639", obs_addr_q[19]); end
            compared++; if (obs_addr_q[20] !== 19'd320) begin failed++; $display("FAIL scroll_21st: got %0d need 320", obs_addr_q[20]); end
            compared++; if (obs_addr_q[319] !== 19'd619) begin failed++; $display("FAIL scroll_last: got %0d need 619", obs_addr_q[319]); end
        end
        nbad = 0; fk = 0;
        for (int k = 0; k < exp_addr_q.size(); k++)
            if (k >= obs_addr_q.size() || obs_addr_q[k] !== exp_addr_q[k]) begin if (nbad == 0) fk = k; nbad++; end
        compared++; if (nbad != 0) begin failed++; $display("FAIL scroll_seq: %0d wrong, first col %0d need %0d", nbad, fk, exp_addr_q[fk]); end
    endtask

    task automatic test_swap_pixels();
        int nbad, fk;
        clear_obs();
        drive_line(1, 0);
        clear_obs();
        drive_line(2, 0);
        // x=5 is sampled at ticks 10 and 11, x=700 at ticks 1400/1401
        compared++; if (obs_pix_q[10] !== 4'd2 || obs_pix_q[11] !== 4'd2) begin failed++; $display("FAIL swap_x5: got %0d/%0d need 2", obs_pix_q[10], obs_pix_q[11]); end
        compared++; if (obs_pix_q[1400] !== 4'd0) begin failed++; $display("FAIL swap_x700: got %0d need 0", obs_pix_q[1400]); end
        nbad = 0; fk = 0;
        for (int k = 0; k < obs_pix_q.size(); k++)
            if (obs_pix_q[k] !== exp_pix_q[k]) begin if (nbad == 0) fk = k; nbad++; end
        compared++; if (nbad != 0) begin failed++; $display("FAIL swap_pixels: %0d wrong, first tick %0d got %0d need %0d", nbad, fk, obs_pix_q[fk], exp_pix_q[fk]); end
    endtask

    task automatic test_frame_wrap();
        int nbad, fk, s;
        int ys [4] = '{479, 500, 524, 0};
        s = int'($urandom_range(0, 511));
        for (int n = 0; n < 4; n++) begin
            clear_obs();
            drive_line(ys[n], s);
            compared++;
            if (busy_cnt !== ((ys[n] >= 479 && ys[n] < 524) ? 0 : 321)) begin
                failed++; $display("FAIL wrap_busy_y%0d: got %0d busy cycles", ys[n], busy_cnt);
            end
            nbad = 0; fk = 0;
            for (int k = 0; k < exp_addr_q.size(); k++)
                if (k >= obs_addr_q.size() || obs_addr_q[k] !== exp_addr_q[k]) begin if (nbad == 0) fk = k; nbad++; end
            for (int k = 0; k < obs_pix_q.size(); k++)
                if (obs_pix_q[k] !== exp_pix_q[k]) begin if (nbad == 0) fk = k; nbad++; end
            compared++; if (nbad != 0) begin failed++; $display("FAIL wrap_line_y%0d: %0d address/pixel errors, first index %0d", ys[n], nbad, fk); end
            s = int'($urandom_range(0, 511));
        end
        // Line 524 fetched source row 0 for line 0
        compared++; if (m_front_valid !== 1'b1 || pixel_data !== 4'd0) begin failed++; $display("FAIL wrap_tail: got pixel %0d need 0 at DrawX=799", pixel_data); end
    endtask

    task automatic test_overrun();
        int nbad, fk, s1, s2;
        s1 = int'($urandom_range(0, 511));
        s2 = int'($urandom_range(0, 511));
        clear_obs();
        partial_line(3, s1, 100);
        compared++; if (overrun !== 1'b0) begin failed++; $display("FAIL ovr_before: got %0b need 0", overrun); end
        clear_obs();
        drive_line(3, s2);
        compared++; if (overrun !== 1'b1) begin failed++; $display("FAIL ovr_set: got %0b need 1", overrun); end
        compared++; if (obs_addr_q.size() == 0 || obs_addr_q[0] !== 19'(640 + s2 % 320)) begin failed++; $display("FAIL ovr_restart: got %0d need %0d", (obs_addr_q.size() > 0) ? obs_addr_q[0] : 19'd0, 640 + s2 % 320); end
        compared++; if (busy_cnt !== 321) begin failed++; $display("FAIL ovr_busy_len: got %0d need 321", busy_cnt); end
        nbad = 0; fk = 0;
        for (int k = 0; k < obs_pix_q.size(); k++)
            if (obs_pix_q[k] !== exp_pix_q[k]) begin if (nbad == 0) fk = k; nbad++; end
        compared++; if (nbad != 0) begin failed++; $display("FAIL ovr_noswap_pix: %0d wrong, first tick %0d got %0d need %0d", nbad, fk, obs_pix_q[fk], exp_pix_q[fk]); end
        clear_obs();
        drive_line(4, 0);
        nbad = 0; fk = 0;
        for (int k = 0; k < obs_pix_q.size(); k++)
            if (obs_pix_q[k] !== exp_pix_q[k]) begin if (nbad == 0) fk = k; nbad++; end
        compared++; if (nbad != 0) begin failed++; $display("FAIL ovr_next_pix: %0d wrong, first tick %0d got %0d need %0d", nbad, fk, obs_pix_q[fk], exp_pix_q[fk]); end
        compared++; if (overrun !== 1'(m_overrun)) begin failed++; $display("FAIL ovr_sticky: got %0b need %0b", overrun, m_overrun); end
    endtask

    task automatic test_reset_midfetch();
        int nbad, fk, nz;
        clear_obs();
        partial_line(5, int'($urandom_range(0, 511)), 151);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        m_reset();
        compared++; if (busy !== 1'b0) begin failed++; $display("FAIL rst_mid_busy: got %0b need 0", busy); end
        compared++; if (pixel_data !== 4'd0) begin failed++; $display("FAIL rst_mid_pix: got %0d need 0", pixel_data); end
        compared++; if (overrun !== 1'b0) begin failed++; $display("FAIL rst_mid_overrun: got %0b need 0", overrun); end
        clear_obs();
        drive_line(6, int'($urandom_range(0, 511)));
        nz = 0;
        for (int k = 0; k < obs_pix_q.size(); k++) if (obs_pix_q[k] !== 4'd0) nz++;
        compared++; if (nz != 0) begin failed++; $display("FAIL rst_front_invalid: %0d nonzero pixels need 0", nz); end
        compared++; if (busy_cnt !== 321) begin failed++; $display("FAIL rst_refetch_len: got %0d need 321", busy_cnt); end
        clear_obs();
        drive_line(7, int'($urandom_range(0, 511)));
        nbad = 0; fk = 0;
        for (int k = 0; k < obs_pix_q.size(); k++)
            if (obs_pix_q[k] !== exp_pix_q[k]) begin if (nbad == 0) fk = k; nbad++; end
        compared++; if (nbad != 0) begin failed++; $display("FAIL rst_recover_pix: %0d wrong, first tick %0d got %0d need %0d", nbad, fk, obs_pix_q[fk], exp_pix_q[fk]); end
    endtask

    task automatic test_random_lines();
        int nbad, fk, y, s;
        for (int n = 0; n < 8; n++) begin
            y = (n == 0) ? 100 : int'($urandom_range(0, 524));
            s = int'($urandom_range(0, 511));
            clear_obs();
            drive_line(y, s);
            compared++;
            if (busy_cnt !== (exp_addr_q.size() != 0 ? 321 : 0)) begin
                failed++; $display("FAIL rand_busy_y%0d: got %0d busy cycles", y, busy_cnt);
            end
            nbad = 0; fk = 0;
            for (int k = 0; k < exp_addr_q.size(); k++)
                if (k >= obs_addr_q.size() || obs_addr_q[k] !== exp_addr_q[k]) begin if (nbad == 0) fk = k; nbad++; end
            compared++; if (nbad != 0) begin failed++; $display("FAIL rand_addr_y%0d_s%0d: %0d wrong, first col %0d need %0d", y, s, nbad, fk, exp_addr_q[fk]); end
            nbad = 0; fk = 0;
            for (int k = 0; k < obs_pix_q.size(); k++)
                if (obs_pix_q[k] !== exp_pix_q[k]) begin if (nbad == 0) fk = k; nbad++; end
            compared++; if (nbad != 0) begin failed++; $display("FAIL rand_pix_y%0d: %0d wrong, first tick %0d got %0d need %0d", y, nbad, fk, obs_pix_q[fk], exp_pix_q[fk]); end
        end
    endtask

    initial begin
        Reset = 1'b1; DrawX = 10'd799; DrawY = 10'd0; scroll_x = 9'd0;
        m_reset();
        test_reset();
        test_fetch_scroll0();
        test_scroll();
        test_swap_pixels();
        ram_mode = 1'b1;
        test_frame_wrap();
        test_overrun();
        test_reset_midfetch();
        test_random_lines();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
